// File: rtl/spart_pkg.sv
// Shared definitions for the SPART processor-side bus controller:
// register addresses, STATUS bit positions and the divisor width.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DIV_LO = 2'b10;
    localparam logic [1:0] ADDR_DIV_HI = 2'b11;

    localparam int ST_RDA      = 0;
    localparam int ST_TBR      = 1;
    localparam int ST_RX_OVF   = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_TX_EMPTY = 4;
    localparam int ST_IRQ_CFG  = 7;

    localparam int DIV_W = 16;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is presented combinationally
// and reads as zero while empty. A push into a full FIFO succeeds only with a pop.
module spart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spart_bus_ctrl.sv
// Processor-side SPART bus controller: TX/RX FIFOs, baud divisor, sticky status.
// Define SPART_BUS_IRQ_EN to add the IRQ-enable register and a live irq output.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               TX_DEPTH  = 8,
    parameter int               RX_DEPTH  = 8,
    parameter logic [DIV_W-1:0] DIV_RESET = 16'd325
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iocs,
    input  logic              iorw,
    input  logic [1:0]        ioaddr,
    inout  wire  [DATA_W-1:0] databus,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DIV_W-1:0]  divisor,
    output logic              div_update,
    output logic              irq
);
    logic              rd_en, wr_en;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic              rx_ovf, tx_ovf;
    logic              rx_ovf_set, tx_ovf_set;
    logic              status_wr, w1c_en;
    logic [DATA_W-1:0] status_vec;
    logic [DATA_W-1:0] rd_data;

    assign rd_en     = iocs & iorw;
    assign wr_en     = iocs & ~iorw;
    assign tx_push   = wr_en && (ioaddr == ADDR_DATA);
    assign rx_pop    = rd_en && (ioaddr == ADDR_DATA);
    assign status_wr = wr_en && (ioaddr == ADDR_STATUS);
    assign tx_pop    = tx_valid & tx_ready;
    assign tx_valid  = ~tx_empty;

    // A full FIFO only overflows when nothing leaves it in the same cycle.
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_set = rx_valid & rx_full & ~(rx_pop & ~rx_empty);

    spart_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(databus),
        .dout(tx_data), .full(tx_full), .empty(tx_empty)
    );

    spart_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop), .din(rx_data),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    always_comb begin
        status_vec              = '0;
        status_vec[ST_RDA]      = ~rx_empty;
        status_vec[ST_TBR]      = ~tx_full;
        status_vec[ST_RX_OVF]   = rx_ovf;
        status_vec[ST_TX_OVF]   = tx_ovf;
        status_vec[ST_TX_EMPTY] = tx_empty;
    end

    always_comb begin
        rd_data = '0;
        case (ioaddr)
            ADDR_DATA:   rd_data = rx_head;
            ADDR_STATUS: rd_data = status_vec;
            ADDR_DIV_LO: rd_data[7:0] = divisor[7:0];
            default:     rd_data[7:0] = divisor[15:8];
        endcase
    end

    assign databus = rd_en ? rd_data : {DATA_W{1'bz}};

`ifdef SPART_BUS_IRQ_EN
    logic [7:0] irq_en;

    // A STATUS write with bit7 set loads the enables instead of clearing flags.
    assign w1c_en = status_wr & ~databus[ST_IRQ_CFG];

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (status_wr && databus[ST_IRQ_CFG]) irq_en <= databus[7:0];
            irq <= |(irq_en & {4'b0000, tx_ovf, rx_ovf, ~tx_full, ~rx_empty});
        end
    end
`else
    assign w1c_en = status_wr;
    assign irq    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ovf     <= 1'b0;
            tx_ovf     <= 1'b0;
            divisor    <= DIV_RESET;
            div_update <= 1'b0;
        end else begin
            rx_ovf     <= rx_ovf_set | (rx_ovf & ~(w1c_en & databus[ST_RX_OVF]));
            tx_ovf     <= tx_ovf_set | (tx_ovf & ~(w1c_en & databus[ST_TX_OVF]));
            div_update <= wr_en && (ioaddr == ADDR_DIV_LO || ioaddr == ADDR_DIV_HI);
            if (wr_en && ioaddr == ADDR_DIV_LO) divisor[7:0]  <= databus[7:0];
            if (wr_en && ioaddr == ADDR_DIV_HI) divisor[15:8] <= databus[7:0];
        end
    end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Directed bench for spart_bus_ctrl: bus reads and TX output are scored against
// expected values queued when the stimulus is driven.
module tb_spart_bus_ctrl;
    import spart_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iocs = 1'b0;
    logic        iorw = 1'b0;
    logic [1:0]  ioaddr = 2'b00;
    logic [7:0]  bus_drv = 8'h00;
    logic        bus_oe = 1'b0;
    wire  [7:0]  databus;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] divisor;
    logic        div_update;
    logic        irq;

    logic [7:0]  exp_q[$];
    logic [7:0]  tx_exp_q[$];
    logic [7:0]  rx_model[$];
    int          errors = 0;
    int          checks = 0;

    assign databus = bus_oe ? bus_drv : 8'hzz;

    spart_bus_ctrl dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .divisor(divisor), .div_update(div_update), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle, optionally with an RX push in the same cycle.
    task automatic cycle(input logic cs, input logic rw, input logic [1:0] addr,
                         input logic [7:0] wdata, input logic rxv, input logic [7:0] rxd,
                         output logic [7:0] rdata);
        @(negedge clk);
        iocs = cs; iorw = rw; ioaddr = addr;
        bus_oe = cs & ~rw; bus_drv = wdata;
        rx_valid = rxv; rx_data = rxd;
        #1 rdata = databus;
        @(posedge clk);
        #1;
        iocs = 1'b0; iorw = 1'b0; bus_oe = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic idle();
        logic [7:0] d;
        cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, d);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [7:0] wdata);
        logic [7:0] d;
        cycle(1'b1, 1'b0, addr, wdata, 1'b0, 8'h00, d);
    endtask

    task automatic read_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        exp_q.push_back(exp);
        cycle(1'b1, 1'b1, addr, 8'h00, 1'b0, 8'h00, d);
        check(tag, {8'h00, d}, {8'h00, exp_q.pop_front()});
    endtask

    task automatic rx_push(input logic [7:0] b);
        logic [7:0] d;
        if (rx_model.size() < 8) rx_model.push_back(b);
        cycle(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, b, d);
    endtask

    task automatic read_rx(input string tag);
        logic [7:0] e;
        e = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
        read_chk(tag, ADDR_DATA, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx_model.delete();
        tx_exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        int guard;

        // Reset defaults
        do_reset();
        check("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("rst_tx_data", {8'h00, tx_data}, 16'd0);
        check("rst_divisor", divisor, 16'd325);
        check("rst_div_update", {15'd0, div_update}, 16'd0);
        check("rst_irq", {15'd0, irq}, 16'd0);
        read_chk("rst_status", ADDR_STATUS, 8'h12);
        read_chk("rst_div_lo", ADDR_DIV_LO, 8'h45);
        read_chk("rst_div_hi", ADDR_DIV_HI, 8'h01);

        // TX overflow with transmitter stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus_write(ADDR_DATA, 8'(i));
            if (i < 8) tx_exp_q.push_back(8'(i));
            if (i == 0) begin
                check("tx_lat_valid", {15'd0, tx_valid}, 16'd1);
                check("tx_lat_data", {8'h00, tx_data}, 16'h0000);
            end
        end
        read_chk("tx_ovf_status", ADDR_STATUS, 8'h08);

        @(negedge clk);
        tx_ready = 1'b1;
        guard = 0;
        while (tx_exp_q.size() > 0 && guard < 20) begin
            #1;
            check("tx_drain_valid", {15'd0, tx_valid}, 16'd1);
            check("tx_drain_data", {8'h00, tx_data}, {8'h00, tx_exp_q.pop_front()});
            @(negedge clk);
            guard++;
        end
        tx_ready = 1'b0;
        check("tx_drain_left", 16'(tx_exp_q.size()), 16'd0);
        #1 check("tx_empty_valid", {15'd0, tx_valid}, 16'd0);
        read_chk("tx_sticky_status", ADDR_STATUS, 8'h1A);
        bus_write(ADDR_STATUS, 8'h08);
        read_chk("tx_w1c_status", ADDR_STATUS, 8'h12);

        // RX fill and drain, empty read
        rx_push(8'hA5);
        read_chk("rx_rda_lat", ADDR_STATUS, 8'h13);
        rx_push(8'h5A);
        read_rx("rx_read0");
        read_rx("rx_read1");
        read_rx("rx_read_empty");
        read_rx("rx_read_empty2");
        read_chk("rx_empty_status", ADDR_STATUS, 8'h12);

        // RX full: same-cycle push and pop keeps count, no overflow
        for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
        read_chk("rx_full_status", ADDR_STATUS, 8'h13);
        exp_q.push_back(rx_model.pop_front());
        rx_model.push_back(8'h77);
        cycle(1'b1, 1'b1, ADDR_DATA, 8'h00, 1'b1, 8'h77, d);
        check("rx_pushpop_data", {8'h00, d}, {8'h00, exp_q.pop_front()});
        read_chk("rx_pushpop_status", ADDR_STATUS, 8'h13);

        // Overflow while full, then set beats a same-cycle clear
        rx_push(8'h99);
        read_chk("rx_ovf_status", ADDR_STATUS, 8'h17);
        cycle(1'b1, 1'b0, ADDR_STATUS, 8'h04, 1'b1, 8'hEE, d);
        read_chk("rx_set_wins", ADDR_STATUS, 8'h17);
        bus_write(ADDR_STATUS, 8'h04);
        read_chk("rx_w1c_status", ADDR_STATUS, 8'h13);
        for (int i = 0; i < 9; i++) read_rx("rx_drain");
        read_chk("rx_drained_status", ADDR_STATUS, 8'h12);

        // Divisor writes
        bus_write(ADDR_DIV_LO, 8'h8B);
        check("div_lo_value", divisor, 16'h018B);
        check("div_lo_pulse", {15'd0, div_update}, 16'd1);
        idle();
        check("div_lo_pulse_end", {15'd0, div_update}, 16'd0);
        bus_write(ADDR_DIV_HI, 8'h02);
        check("div_hi_value", divisor, 16'h028B);
        check("div_hi_pulse", {15'd0, div_update}, 16'd1);
        idle();
        check("div_hi_pulse_end", {15'd0, div_update}, 16'd0);
        read_chk("div_lo_read", ADDR_DIV_LO, 8'h8B);
        read_chk("div_hi_read", ADDR_DIV_HI, 8'h02);

        // IRQ behaviour
        bus_write(ADDR_STATUS, 8'h81);
        read_chk("irqcfg_status", ADDR_STATUS, 8'h12);
        rx_push(8'h3C);
        check("irq_n1", {15'd0, irq}, 16'd0);
        idle();
`ifdef SPART_BUS_IRQ_EN
        check("irq_n2", {15'd0, irq}, 16'd1);
        read_rx("irq_read");
        check("irq_hold", {15'd0, irq}, 16'd1);
        idle();
        check("irq_clear", {15'd0, irq}, 16'd0);
`else
        check("irq_tied", {15'd0, irq}, 16'd0);
        read_rx("irq_read");
        check("irq_tied2", {15'd0, irq}, 16'd0);
`endif

        // Reset mid-operation flushes FIFOs and restores divisor
        bus_write(ADDR_DATA, 8'hC3);
        rx_push(8'h42);
        do_reset();
        check("mid_rst_tx_valid", {15'd0, tx_valid}, 16'd0);
        check("mid_rst_divisor", divisor, 16'd325);
        read_chk("mid_rst_status", ADDR_STATUS, 8'h12);
        read_rx("mid_rst_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
